vga_sync_gen: RTL

VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

---
 rtl/vga_sync_gen.sv | 91 +++++++++
 1 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen
//   Pixel/line counter and sync decoder for a raster display. hpos runs
//   0..H_TOTAL-1 across a line, vpos runs 0..V_TOTAL-1 down a frame, and
//   both advance only on cycles where en is high. Every status output is a
//   zero-latency decode of the hpos/vpos registers, so it is aligned with
//   the pixel position it describes.
//
// Ports
//   clk        in   clock, rising edge
//   reset      in   synchronous active-high reset, priority over en
//   en         in   pixel advance enable
//   hpos[9:0]  out  horizontal pixel counter
//   vpos[9:0]  out  line counter
//   visible    out  position is inside the active area
//   hsync_n    out  horizontal sync, active low
//   vsync_n    out  vertical sync, active low
//   hmax       out  last pixel of a line
//   vmax       out  last line of a frame
//   frame_end  out  last pixel of the frame
//
// H_TOTAL and V_TOTAL must each be no larger than 1024.

module vga_sync_gen #(
  parameter int H_VIEW  = 640,
  parameter int H_FRONT = 16,
  parameter int H_SYNC  = 96,
  parameter int H_BACK  = 48,
  parameter int V_VIEW  = 480,
  parameter int V_FRONT = 10,
  parameter int V_SYNC  = 2,
  parameter int V_BACK  = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  output logic [9:0] hpos,
  output logic [9:0] vpos,
  output logic       visible,
  output logic       hsync_n,
  output logic       vsync_n,
  output logic       hmax,
  output logic       vmax,
  output logic       frame_end
);

  localparam int H_TOTAL = H_VIEW + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VIEW + V_FRONT + V_SYNC + V_BACK;

  // Thresholds are held at 11 bits so a region boundary equal to 1024
  // (e.g. H_VIEW = 1024 with zero porches) still compares correctly
  // against the zero-extended 10-bit counters.
  localparam logic [10:0] H_VIEW_END  = 11'(H_VIEW);
  localparam logic [10:0] H_SYNC_BEG  = 11'(H_VIEW + H_FRONT);
  localparam logic [10:0] H_SYNC_END  = 11'(H_VIEW + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIEW_END  = 11'(V_VIEW);
  localparam logic [10:0] V_SYNC_BEG  = 11'(V_VIEW + V_FRONT);
  localparam logic [10:0] V_SYNC_END  = 11'(V_VIEW + V_FRONT + V_SYNC);
  localparam logic [9:0]  H_LAST      = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST      = 10'(V_TOTAL - 1);

  logic [10:0] hpos_w;
  logic [10:0] vpos_w;

  assign hpos_w = {1'b0, hpos};
  assign vpos_w = {1'b0, vpos};

  assign hmax      = (hpos == H_LAST);
  assign vmax      = (vpos == V_LAST);
  assign frame_end = hmax && vmax;

  assign visible = (hpos_w < H_VIEW_END) && (vpos_w < V_VIEW_END);
  assign hsync_n = !((hpos_w >= H_SYNC_BEG) && (hpos_w < H_SYNC_END));
  assign vsync_n = !((vpos_w >= V_SYNC_BEG) && (vpos_w < V_SYNC_END));

  // vpos only moves on the cycle hpos wraps; both wrap together at frame end.
  always_ff @(posedge clk) begin
    if (reset) begin
      hpos <= '0;
      vpos <= '0;
    end else if (en) begin
      if (hmax) begin
        hpos <= '0;
        if (vmax) vpos <= '0;
        else      vpos <= vpos + 10'd1;
      end else begin
        hpos <= hpos + 10'd1;
      end
    end
  end

endmodule
